// File: rtl/compositor_pkg.sv
// Shared constants and helpers for the layer compositor: default palette
// colours (authored at 12-bit 4:4:4), palette slot offsets and colour scaling.
package compositor_pkg;

  localparam logic [11:0] DEF_L0    = 12'hAAA;
  localparam logic [11:0] DEF_L1    = 12'hF00;
  localparam logic [11:0] DEF_L2    = 12'h0FF;
  localparam logic [11:0] DEF_BG    = 12'hFFF;
  localparam logic [11:0] DEF_FLASH = 12'hF0F;

  // Palette slots after the layer entries, as offsets from NUM_LAYERS.
  localparam int BG_IDX    = 0;
  localparam int FLASH_IDX = 1;

  // Rescale a 12-bit 4:4:4 colour to rgb_w bits (rgb_w/3 per channel) by
  // repeating each channel's bits MSB-first; narrowing keeps the top bits.
  // The result sits in the low rgb_w bits.
  function automatic logic [63:0] scale_color(input logic [11:0] c, input int rgb_w);
    logic [63:0] res;
    int cw;
    res = '0;
    cw  = rgb_w / 3;
    for (int ch = 0; ch < 3; ch++) begin
      for (int j = 0; j < 21; j++) begin
        if (j < cw) res[6'(ch * cw + cw - 1 - j)] = c[4'(ch * 4 + 3 - (j % 4))];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter shared by blink and flash logic. WRAP=1: counts ticks
// 0..LIMIT and wraps; zero strobes on the tick that returns the count to 0.
// WRAP=0: load sets the count, ticks decrement it down to 0 and it holds;
// zero is a level flag. Load always wins over a coincident tick.
module frame_timer
  import compositor_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_p0;

  // Counter state: load first, then tick-driven wrap or decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_p0 <= '0;
    end else if (load) begin
      count_p0 <= load_val;
    end else if (tick) begin
      if (WRAP) begin
        count_p0 <= (count_p0 == LIMIT_V) ? '0 : count_p0 + WIDTH'(1);
      end else if (count_p0 != '0) begin
        count_p0 <= count_p0 - WIDTH'(1);
      end
    end
  end

  generate
    if (WRAP) begin : g_wrap
      assign zero = tick & ~load & (count_p0 == LIMIT_V);
    end else begin : g_dec
      assign zero = (count_p0 == '0);
    end
  endgenerate

endmodule

// File: rtl/layer_compositor.sv
// Priority pixel compositor: per-layer hit flags resolved against a
// programmable palette, with per-layer blink and a timed full-screen flash
// that replaces only the background. Pixel and syncs leave on the same edge.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int RGB_W        = 12,
  parameter int BLINK_FRAMES = 16,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              video_on,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic                              frame_tick,
  input  logic [NUM_LAYERS-1:0]             layer_on,
  input  logic [NUM_LAYERS-1:0]             layer_en,
  input  logic [NUM_LAYERS-1:0]             blink_en,
  input  logic                              flash_req,
  input  logic                              wr_en,
  input  logic [$clog2(NUM_LAYERS+2)-1:0]   wr_addr,
  input  logic [RGB_W-1:0]                  wr_data,
  output logic [RGB_W-1:0]                  rgb,
  output logic                              hsync,
  output logic                              vsync,
  output logic                              flash_active
);

  localparam int NE    = NUM_LAYERS + 2;
  localparam int BG    = NUM_LAYERS + BG_IDX;
  localparam int FL    = NUM_LAYERS + FLASH_IDX;
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam int FLS_W = $clog2(FLASH_FRAMES + 1);

  function automatic logic [RGB_W-1:0] def_color(input int idx);
    logic [63:0] w;
    if (idx == FL)      w = scale_color(DEF_FLASH, RGB_W);
    else if (idx == BG) w = scale_color(DEF_BG, RGB_W);
    else if (idx == 0)  w = scale_color(DEF_L0, RGB_W);
    else if (idx == 1)  w = scale_color(DEF_L1, RGB_W);
    else if (idx == 2)  w = scale_color(DEF_L2, RGB_W);
    else                w = '0;
    return w[RGB_W-1:0];
  endfunction

  logic [RGB_W-1:0]      pal [NE];
  logic                  blink_phase;
  logic                  blink_wrap;
  logic                  flash_zero;
  logic [NUM_LAYERS-1:0] hit_p0;
  logic [RGB_W-1:0]      rgb_p0;
  logic [RGB_W-1:0]      rgb_p1;
  logic                  hsync_p1;
  logic                  vsync_p1;

  frame_timer #(
    .WIDTH (BLK_W),
    .LIMIT (BLINK_FRAMES - 1),
    .WRAP  (1'b1)
  ) u_blink (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .tick     (frame_tick),
    .zero     (blink_wrap)
  );

  frame_timer #(
    .WIDTH (FLS_W),
    .LIMIT (0),
    .WRAP  (1'b0)
  ) u_flash (
    .clk      (clk),
    .reset    (reset),
    .load     (flash_req),
    .load_val (FLS_W'(FLASH_FRAMES)),
    .tick     (frame_tick),
    .zero     (flash_zero)
  );

  assign flash_active = ~flash_zero;

  // Blink phase starts visible and flips each time the blink counter wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           blink_phase <= 1'b1;
    else if (blink_wrap) blink_phase <= ~blink_phase;
  end

  // Palette registers; a write lands on the edge, so same-cycle reads see the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) pal[i] <= def_color(i);
    end else if (wr_en && (int'(wr_addr) < NE)) begin
      pal[wr_addr] <= wr_data;
    end
  end

  // Stage 0: effective hits and priority select (lowest index wins).
  always_comb begin
    hit_p0 = layer_on & layer_en & (~blink_en | {NUM_LAYERS{blink_phase}});
    rgb_p0 = flash_active ? pal[FL] : pal[BG];
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit_p0[i]) rgb_p0 = pal[i];
    end
    if (!video_on) rgb_p0 = '0;
  end

  // Stage 1: register pixel and syncs together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_p1   <= '0;
      hsync_p1 <= 1'b0;
      vsync_p1 <= 1'b0;
    end else begin
      rgb_p1   <= rgb_p0;
      hsync_p1 <= hsync_in;
      vsync_p1 <= vsync_in;
    end
  end

  assign rgb   = rgb_p1;
  assign hsync = hsync_p1;
  assign vsync = vsync_p1;

endmodule
